// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and the control payload routed
// from the owning bus unit onto the shared master port.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_OWN     = 2'd1,
    ST_HANDOFF = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic [1:0] htrans;
    logic       hmastlock;
  } ahb_ctrl_t;

  localparam ahb_ctrl_t CTRL_IDLE = '{
    hwrite:    1'b0,
    hsize:     3'b000,
    hburst:    HBURST_SINGLE,
    hprot:     HPROT_DEFAULT,
    htrans:    HTRANS_IDLE,
    hmastlock: 1'b0
  };

  // Encode a one-hot grant (up to 8 requesters) into its index.
  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after position
// 'start', wrapping around; one-hot result, zero when nothing requests.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   start,
  output logic [N-1:0] grant
);

  logic found;

  // Pass 0 scans [start, N), pass 1 wraps and scans [0, start).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!found && req[j] && ((pass == 0) == (j >= int'(start)))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB master port between the MMU walker (fixed priority) and the
// cache bus units (round-robin); ownership only changes via an idle handoff.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   bus_req,
  output logic [NREQ-1:0]   bus_ack,
  input  logic [NREQ*AW-1:0] m_haddr,
  input  logic [NREQ-1:0]   m_hwrite,
  input  logic [NREQ*3-1:0] m_hsize,
  input  logic [NREQ*3-1:0] m_hburst,
  input  logic [NREQ*4-1:0] m_hprot,
  input  logic [NREQ*2-1:0] m_htrans,
  input  logic [NREQ-1:0]   m_hmastlock,
  input  logic [NREQ*DW-1:0] m_hwdata,
  output logic [NREQ-1:0]   m_hready,
  output logic [NREQ-1:0]   m_hresp,
  output logic [DW-1:0]     m_hrdata,
  output logic [AW-1:0]     haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [1:0]        htrans,
  output logic              hmastlock,
  output logic [DW-1:0]     hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DW-1:0]     hrdata,
  output logic [2:0]        owner,
  output logic              hold_timeout
);

  localparam int unsigned RRN = NREQ - 1;
  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

  arb_state_e      state;
  logic [NREQ-1:0] owner_oh;
  logic [2:0]      rr_ptr;
  logic [HCW-1:0]  hold_cnt;

  logic [RRN-1:0]  rr_grant;
  logic [NREQ-1:0] win;
  logic [2:0]      win_idx;
  logic [2:0]      rr_ptr_nxt;
  logic            owner_req;
  logic            others_pending;

  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  ahb_ctrl_t       sel_ctrl;
  ahb_ctrl_t       unit_ctrl;
  ahb_ctrl_t       out_ctrl;

  // Units 1..NREQ-1 share the round-robin; the picker works in 0-based slots.
  rr_pick #(.N(RRN)) u_rr_pick (
    .req   (bus_req[NREQ-1:1]),
    .start (rr_ptr - 3'd1),
    .grant (rr_grant)
  );

  always_comb begin
    if (bus_req[0]) win = {{(NREQ-1){1'b0}}, 1'b1};
    else            win = {rr_grant, 1'b0};
    win_idx        = oh_to_idx(8'(win));
    rr_ptr_nxt     = (win_idx == 3'(NREQ - 1)) ? 3'd1 : win_idx + 3'd1;
    owner_req      = |(bus_req & owner_oh);
    others_pending = |(bus_req & ~owner_oh);
  end

  // owner_oh survives HANDOFF so the drained data phase still reaches its unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ARB;
      bus_ack      <= '0;
      owner_oh     <= '0;
      owner        <= 3'd0;
      rr_ptr       <= 3'd1;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      hold_timeout <= 1'b0;
      unique case (state)
        ST_ARB: begin
          if (|bus_req) begin
            state    <= ST_OWN;
            bus_ack  <= win;
            owner_oh <= win;
            owner    <= win_idx;
            if (!bus_req[0]) rr_ptr <= rr_ptr_nxt;
          end
        end
        ST_OWN: begin
          if (!owner_req) begin
            state    <= ST_HANDOFF;
            bus_ack  <= '0;
            hold_cnt <= '0;
          end else if (others_pending && hold_cnt != HCW'(MAX_HOLD - 1)) begin
            hold_cnt     <= hold_cnt + HCW'(1);
            hold_timeout <= (hold_cnt == HCW'(MAX_HOLD - 2));
          end
        end
        ST_HANDOFF: begin
          if (hready) state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // AND-OR select of the current (or draining) owner's request payload.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_ctrl  = '0;
    unit_ctrl = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_oh[i]) begin
        unit_ctrl = '{
          hwrite:    m_hwrite[i],
          hsize:     m_hsize[i*3 +: 3],
          hburst:    m_hburst[i*3 +: 3],
          hprot:     m_hprot[i*4 +: 4],
          htrans:    m_htrans[i*2 +: 2],
          hmastlock: m_hmastlock[i]
        };
        sel_ctrl  = ahb_ctrl_t'(sel_ctrl | unit_ctrl);
        sel_addr  = sel_addr | m_haddr[i*AW +: AW];
        sel_wdata = sel_wdata | m_hwdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    out_ctrl = CTRL_IDLE;
    haddr    = '0;
    hwdata   = '0;
    m_hready = '0;
    m_hresp  = '0;
    if (state != ST_ARB) begin
      out_ctrl = sel_ctrl;
      haddr    = sel_addr;
      hwdata   = sel_wdata;
      m_hready = owner_oh & {NREQ{hready}};
      m_hresp  = owner_oh & {NREQ{hresp}};
      if (state == ST_HANDOFF) out_ctrl.htrans = HTRANS_IDLE;
    end
  end

  assign hwrite    = out_ctrl.hwrite;
  assign hsize     = out_ctrl.hsize;
  assign hburst    = out_ctrl.hburst;
  assign hprot     = out_ctrl.hprot;
  assign htrans    = out_ctrl.htrans;
  assign hmastlock = out_ctrl.hmastlock;
  assign m_hrdata  = hrdata;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_ahb_bus_arbiter;

  localparam int NREQ     = 3;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   bus_req;
  logic [NREQ-1:0]   bus_ack;
  logic [NREQ*AW-1:0] m_haddr;
  logic [NREQ-1:0]   m_hwrite;
  logic [NREQ*3-1:0] m_hsize;
  logic [NREQ*3-1:0] m_hburst;
  logic [NREQ*4-1:0] m_hprot;
  logic [NREQ*2-1:0] m_htrans;
  logic [NREQ-1:0]   m_hmastlock;
  logic [NREQ*DW-1:0] m_hwdata;
  logic [NREQ-1:0]   m_hready;
  logic [NREQ-1:0]   m_hresp;
  logic [DW-1:0]     m_hrdata;
  logic [AW-1:0]     haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [1:0]        htrans;
  logic              hmastlock;
  logic [DW-1:0]     hwdata;
  logic              hready;
  logic              hresp;
  logic [DW-1:0]     hrdata;
  logic [2:0]        owner;
  logic              hold_timeout;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_ack(bus_ack),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .owner(owner), .hold_timeout(hold_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, who is draining, the round-robin cursor and
  // how many contended cycles the current owner has held.
  int m_own   = -1;
  int m_drain = -1;
  int m_ptr   = 1;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int w;
    m_valid = 1'b1;
    if (rst) begin
      m_own = -1; m_drain = -1; m_ptr = 1; m_cnt = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_own >= 0) begin
        if (!bus_req[m_own]) begin
          m_drain = m_own;
          m_own   = -1;
          m_cnt   = 0;
        end else if ((bus_req & ~(3'b001 << m_own)) != 0 && m_cnt < MAX_HOLD - 1) begin
          m_cnt++;
          if (m_cnt == MAX_HOLD - 1) m_to = 1'b1;
        end
      end else if (m_drain >= 0) begin
        if (hready) m_drain = -1;
      end else if (bus_req != 0) begin
        w = -1;
        if (bus_req[0]) w = 0;
        else begin
          for (int k = 0; k < NREQ - 1; k++) begin
            int c;
            c = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
            if (w < 0 && bus_req[c]) w = c;
          end
          m_ptr = (w == NREQ - 1) ? 1 : w + 1;
        end
        m_own = w;
      end
    end
  end

  always @(negedge clk) begin
    int r;
    if (m_valid) begin
      r = (m_own >= 0) ? m_own : m_drain;
      check("model_ack", bus_ack, (m_own >= 0) ? 64'(3'b001 << m_own) : 64'd0);
      if (m_own >= 0) check("model_owner", owner, 64'(m_own));
      if (r >= 0) begin
        check("model_haddr", haddr, m_haddr[r*AW +: AW]);
        check("model_hwrite", hwrite, m_hwrite[r]);
        check("model_hsize", hsize, m_hsize[r*3 +: 3]);
        check("model_hburst", hburst, m_hburst[r*3 +: 3]);
        check("model_hprot", hprot, m_hprot[r*4 +: 4]);
        check("model_htrans", htrans, (m_own >= 0) ? 64'(m_htrans[r*2 +: 2]) : 64'd0);
        check("model_hmastlock", hmastlock, m_hmastlock[r]);
        check("model_hwdata", hwdata, m_hwdata[r*DW +: DW]);
        check("model_m_hready", m_hready, hready ? 64'(3'b001 << r) : 64'd0);
        check("model_m_hresp", m_hresp, hresp ? 64'(3'b001 << r) : 64'd0);
      end else begin
        check("model_idle_haddr", haddr, 64'd0);
        check("model_idle_ctrl", {hwrite, hsize, hburst, hprot, htrans, hmastlock}, 64'h003 << 3);
        check("model_idle_hwdata", hwdata, 64'd0);
        check("model_idle_m_hready", m_hready, 64'd0);
        check("model_idle_m_hresp", m_hresp, 64'd0);
      end
      check("model_m_hrdata", m_hrdata, hrdata);
      check("model_hold_timeout", hold_timeout, m_to);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(output int w);
    w = -1;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (bus_ack != 0) begin
        w = int'(owner);
        break;
      end
      cyc();
    end
    if (w < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected a grant within 8 cycles at %0t", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1);
  end

  initial begin
    int fair_exp[8] = '{1, 2, 1, 2, 0, 1, 2, 1};
    int w;
    int pulses;
    int pulse_at;

    rst = 1'b1; bus_req = '0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h5A5A_1234;
    for (int i = 0; i < NREQ; i++) begin
      m_haddr[i*AW +: AW]  = 32'hA000_0000 + 32'(i * 16);
      m_hwdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    end
    m_hwrite    = 3'b101;
    m_hsize     = {3'd2, 3'd1, 3'd3};
    m_hburst    = {3'b001, 3'b011, 3'b000};
    m_hprot     = {4'hE, 4'h1, 4'h7};
    m_htrans    = {2'b11, 2'b10, 2'b10};
    m_hmastlock = 3'b010;

    // Reset state
    cyc(); cyc(); sample();
    check("rst_ack", bus_ack, 3'b000);
    check("rst_htrans", htrans, 2'b00);
    check("rst_hprot", hprot, 4'b0011);
    check("rst_m_hready", m_hready, 3'b000);
    check("rst_timeout", hold_timeout, 1'b0);
    cyc(); rst = 1'b0;

    // Single requester, then idle handoff
    bus_req = 3'b100;
    cyc(); sample();
    check("single_ack", bus_ack, 3'b100);
    check("single_owner", owner, 3'd2);
    check("single_haddr", haddr, 32'hA000_0020);
    check("single_htrans", htrans, 2'b11);
    bus_req = 3'b000;
    cyc(); sample();
    check("handoff_ack", bus_ack, 3'b000);
    check("handoff_htrans", htrans, 2'b00);
    check("handoff_haddr", haddr, 32'hA000_0020);
    check("handoff_m_hready", m_hready, 3'b100);
    cyc(); sample();
    check("arb_idle_haddr", haddr, 32'h0);
    check("arb_idle_m_hready", m_hready, 3'b000);

    // Priority then round-robin
    bus_req = 3'b111;
    cyc(); sample();
    check("prio_ack_mmu", bus_ack, 3'b001);
    bus_req = 3'b110;
    cyc(); cyc(); cyc(); sample();
    check("prio_ack_rr1", bus_ack, 3'b010);
    bus_req = 3'b100;
    cyc(); cyc(); cyc(); sample();
    check("prio_ack_rr2", bus_ack, 3'b100);
    bus_req = 3'b000;
    cyc(); cyc();

    // Fairness between units 1 and 2 with an MMU request inserted
    bus_req = 3'b110;
    for (int g = 0; g < 8; g++) begin
      wait_grant(w);
      check("fair_order", 64'(w), 64'(fair_exp[g]));
      cyc();
      if (w >= 0) bus_req[w] = 1'b0;
      if (g == 3) bus_req[0] = 1'b1;
      cyc();
      if (w > 0) bus_req[w] = 1'b1;
    end
    bus_req = 3'b000;
    cyc(); cyc(); cyc();

    // Wait-stated handoff
    bus_req = 3'b010;
    cyc(); sample();
    check("ws_ack", bus_ack, 3'b010);
    bus_req = 3'b000; hready = 1'b0;
    cyc(); sample();
    check("ws_ack0", bus_ack, 3'b000);
    check("ws_htrans0", htrans, 2'b00);
    check("ws_m_hready0", m_hready, 3'b000);
    bus_req = 3'b100;
    for (int k = 0; k < 2; k++) begin
      cyc(); sample();
      check("ws_hold_ack", bus_ack, 3'b000);
      check("ws_hold_htrans", htrans, 2'b00);
    end
    hready = 1'b1; #1;
    check("ws_m_hready1", m_hready, 3'b010);
    cyc(); sample();
    check("ws_arb_ack", bus_ack, 3'b000);
    cyc(); sample();
    check("ws_next_ack", bus_ack, 3'b100);
    bus_req = 3'b000;
    cyc(); cyc();

    // Error response routed to owner only, grant kept
    bus_req = 3'b010;
    cyc(); sample();
    hresp = 1'b1; #1;
    check("err_m_hresp", m_hresp, 3'b010);
    cyc(); sample();
    check("err_ack_held", bus_ack, 3'b010);
    check("err_m_hresp2", m_hresp, 3'b010);
    bus_req = 3'b000; hresp = 1'b0;
    cyc(); cyc();

    // Hold timeout with a pending requester
    bus_req = 3'b100;
    cyc();
    bus_req = 3'b110;
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(); sample();
      if (hold_timeout === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("to_pulses", 64'(pulses), 64'd1);
    check("to_pulse_at", 64'(pulse_at), 64'd7);
    check("to_ack_kept", bus_ack, 3'b100);

    // Reset mid-burst with the slave stalling
    rst = 1'b1; hready = 1'b0;
    cyc(); sample();
    check("mid_rst_ack", bus_ack, 3'b000);
    check("mid_rst_htrans", htrans, 2'b00);
    check("mid_rst_haddr", haddr, 32'h0);
    check("mid_rst_hprot", hprot, 4'b0011);
    check("mid_rst_m_hready", m_hready, 3'b000);
    rst = 1'b0; bus_req = 3'b000; hready = 1'b1;
    cyc();
    bus_req = 3'b110;
    cyc(); sample();
    check("post_rst_ack", bus_ack, 3'b010);
    bus_req = 3'b000;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
